subtractor1_serial: RTL and testbench

Bit-serial, LSB-first full subtractor: the inverse arithmetic direction of the buffered 1-bit full adder. One full-subtractor cell computes difference and borrow. A borrow register chains the bits of a WIDTH-bit word, and a DEPTH-stage register pipeline matches the path-balanced latency of the adder datapath. Sits beside the serial adder lane so that add and subtract results emerge with identical latency and framing.

---
 rtl/subtractor1_serial.sv | 105 ++++++++++
 tb/tb_subtractor1_serial.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor1_serial.sv
// Bit-serial LSB-first full subtractor with a borrow chain spanning WIDTH-bit
// words and a DEPTH-stage output pipeline matching the serial adder latency.
module subtractor1_serial #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic out_valid,
  input  logic out_ready,
  output logic d,
  output logic bout,
  output logic last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);

  function automatic logic diff_bit(input logic x, input logic y, input logic br);
    return x ^ y ^ br;
  endfunction

  function automatic logic borrow_bit(input logic x, input logic y, input logic br);
    return (~x & y) | (~(x ^ y) & br);
  endfunction

  logic [CW-1:0]    cnt_r;
  logic             borrow_r;
  logic [DEPTH-1:0] vld_r;
  logic [DEPTH-1:0] d_r;
  logic [DEPTH-1:0] bout_r;
  logic [DEPTH-1:0] last_r;

  logic stall_s;
  logic accept_s;
  logic br_s;
  logic d_s;
  logic bout_s;
  logic last_s;

  // Handshake and full-subtractor cell; bit 0 of a word takes the word borrow-in.
  always_comb begin
    stall_s  = vld_r[DEPTH-1] & ~out_ready;
    accept_s = in_valid & ~stall_s;
    if (cnt_r == CNT_ZERO) begin
      br_s = bin;
    end else begin
      br_s = borrow_r;
    end
    d_s    = diff_bit(a, b, br_s);
    bout_s = borrow_bit(a, b, br_s);
    last_s = (cnt_r == CNT_MAX);
  end

  // Bit position and borrow chain advance only on accepted bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      borrow_r <= 1'b0;
    end else if (accept_s) begin
      borrow_r <= bout_s;
      if (cnt_r == CNT_MAX) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Output pipeline: every stage shifts together unless the final stage is stalled,
  // so bubbles are preserved and latency stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r  <= {DEPTH{1'b0}};
      d_r    <= {DEPTH{1'b0}};
      bout_r <= {DEPTH{1'b0}};
      last_r <= {DEPTH{1'b0}};
    end else if (!stall_s) begin
      vld_r[0]  <= accept_s;
      d_r[0]    <= d_s;
      bout_r[0] <= bout_s;
      last_r[0] <= last_s;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i]  <= vld_r[i-1];
        d_r[i]    <= d_r[i-1];
        bout_r[i] <= bout_r[i-1];
        last_r[i] <= last_r[i-1];
      end
    end
  end

  assign in_ready  = ~stall_s;
  assign out_valid = vld_r[DEPTH-1];
  assign d         = d_r[DEPTH-1];
  assign bout      = bout_r[DEPTH-1];
  assign last      = last_r[DEPTH-1];

endmodule

// File: tb/tb_subtractor1_serial.sv
// Self-checking bench for subtractor1_serial: word-level arithmetic reference
// model, per-cycle output comparison, directed cases and randomized traffic.
module tb_subtractor1_serial;

  localparam int WIDTH = 8;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, a, b, bin, out_valid, out_ready, d, bout, last;

  always #5 clk = ~clk;

  subtractor1_serial #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .last(last)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {logic d; logic bo; logic last; int mv;} exp_t;
  typedef struct {logic [WIDTH-1:0] dw; logic [WIDTH-1:0] bm; logic bo; int nbits;} word_t;

  exp_t  expq[$];
  exp_t  e;
  word_t words[$];
  word_t w;
  int    moves = 0;
  int    m_pos = 0;
  longint m_a, m_b, m_bin, m_diff;
  logic [WIDTH-1:0] c_dw, c_bm;
  int    c_pos = 0;
  logic  prev_rst = 1'b0;
  int    cyc = 0;
  int    first_acc = -1;
  int    first_ov = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Word-level reference: the whole word difference as a plain integer.
  function automatic logic [WIDTH:0] model_word(input int wa, input int wb, input int wbin);
    int diff;
    diff = wa - wb - wbin;
    return {diff < 0, diff[WIDTH-1:0]};
  endfunction

  // Compare outputs against the model, then book-keep what the next edge does.
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
    end
    prev_rst = rst;
    if (rst) begin
      expq.delete();
      m_pos = 0;
      c_pos = 0;
      first_acc = -1;
      first_ov = -1;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (expq.size() == 0) begin
        check("out_valid idle", 64'(out_valid), 64'd0);
      end else if (moves - expq[0].mv >= DEPTH - 1) begin
        check("out_valid due", 64'(out_valid), 64'd1);
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && expq.size() > 0) begin
        check("d", 64'(d), 64'(expq[0].d));
        check("bout", 64'(bout), 64'(expq[0].bo));
        check("last", 64'(last), 64'(expq[0].last));
        check("latency", 64'(moves - expq[0].mv), 64'(DEPTH - 1));
        if (out_ready) begin
          if (c_pos < WIDTH) begin
            c_dw[c_pos] = d;
            c_bm[c_pos] = bout;
          end
          c_pos++;
          if (last) begin
            w.dw = c_dw; w.bm = c_bm; w.bo = bout; w.nbits = c_pos;
            words.push_back(w);
            c_pos = 0;
          end
          void'(expq.pop_front());
        end
      end
      if (!(out_valid && !out_ready)) moves++;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        if (m_pos == 0) begin
          m_a = 0; m_b = 0; m_bin = longint'(bin);
        end
        m_a = m_a | (longint'(a) << m_pos);
        m_b = m_b | (longint'(b) << m_pos);
        m_diff = m_a - m_b - m_bin;
        e.d = m_diff[m_pos];
        e.bo = (m_diff < 0);
        e.last = (m_pos == WIDTH - 1);
        e.mv = moves;
        expq.push_back(e);
        m_pos = (m_pos + 1) % WIDTH;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gaps: 0 none, 1 one idle cycle before each bit, 2 random idle cycles.
  task automatic send_word(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                           input logic wbin, input int gaps, input bit rbp,
                           input int stall_at, input int nbits);
    logic acc;
    int t;
    for (int i = 0; i < nbits; i++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        a = 1'($urandom); b = 1'($urandom); bin = 1'($urandom);
        out_ready = rbp ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
      end
      if (i == stall_at) begin
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1; a = wa[i]; b = wb[i]; bin = 1'($urandom);
          out_ready = 1'b0;
          @(negedge clk);
          check("stall in_ready", 64'(in_ready), 64'd0);
          tick();
        end
      end
      in_valid = 1'b1;
      a = wa[i];
      b = wb[i];
      bin = (i == 0) ? wbin : 1'($urandom);
      t = 0;
      do begin
        out_ready = rbp ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        acc = in_ready;
        tick();
        t++;
      end while (!acc && t < 100);
      if (!acc) check("accept timeout", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (expq.size() > 0 && t < 300) begin
      tick();
      t++;
    end
    tick();
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  task automatic check_word(input string name, input int idx, input logic [WIDTH-1:0] dw,
                            input logic bo);
    if (words.size() > idx) begin
      check({name, " d"}, 64'(words[idx].dw), 64'(dw));
      check({name, " bout"}, 64'(words[idx].bo), 64'(bo));
      check({name, " nbits"}, 64'(words[idx].nbits), 64'(WIDTH));
    end else begin
      check({name, " present"}, 64'(words.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 1'b0; b = 1'b0; bin = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    check("model 5A-3C", 64'(model_word(32'h5A, 32'h3C, 0)), 64'h01E);
    check("model 00-01", 64'(model_word(32'h00, 32'h01, 0)), 64'h1FF);
    check("model 10-01-1", 64'(model_word(32'h10, 32'h01, 1)), 64'h00E);

    words.delete();
    send_word(8'h5A, 8'h3C, 1'b0, 0, 1'b0, -1, WIDTH);
    drain();
    check_word("5A-3C", 0, 8'h1E, 1'b0);
    check("first out_valid delay", 64'(first_ov - first_acc), 64'(DEPTH));

    words.delete();
    send_word(8'h00, 8'h01, 1'b0, 0, 1'b0, -1, WIDTH);
    drain();
    check_word("00-01", 0, 8'hFF, 1'b1);
    if (words.size() > 0) check("00-01 bout mask", 64'(words[0].bm), 64'hFF);

    words.delete();
    send_word(8'h10, 8'h01, 1'b1, 0, 1'b0, -1, WIDTH);
    send_word(8'h03, 8'h01, 1'b0, 0, 1'b0, -1, WIDTH);
    drain();
    check_word("10-01-1", 0, 8'h0E, 1'b0);
    check_word("03-01", 1, 8'h02, 1'b0);

    words.delete();
    send_word(8'hA5, 8'h5A, 1'b0, 0, 1'b0, DEPTH, WIDTH);
    drain();
    check_word("A5-5A stall", 0, 8'h4B, 1'b0);
    check("A5-5A word count", 64'(words.size()), 64'd1);

    words.delete();
    send_word(8'h80, 8'h01, 1'b0, 1, 1'b0, -1, WIDTH);
    drain();
    check_word("80-01 gaps", 0, 8'h7F, 1'b0);

    words.delete();
    send_word(8'hFF, 8'h00, 1'b1, 0, 1'b0, -1, 4);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    words.delete();
    send_word(8'h07, 8'h02, 1'b0, 0, 1'b0, -1, WIDTH);
    drain();
    check_word("07-02 after reset", 0, 8'h05, 1'b0);
    check("reset word count", 64'(words.size()), 64'd1);

    words.delete();
    for (int n = 0; n < 40; n++) begin
      send_word(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 2, 1'b1, -1, WIDTH);
    end
    drain();
    check("random word count", 64'(words.size()), 64'd40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
